output_port: RTL and testbench
==============================

// Module: output_port
// PURPOSE
//  Per-direction output stage of the NoC router: collects 32-bit packets from the VC read
//  ports of every input module that target this direction.
//  It round-robin arbitrates among them, buffers winners in a small FIFO, and drives the
//  outbound link (adjacent router or network interface) with a valid/ready handshake.
//  One instance per output direction (N, S, E, W, Local). Single-flit packets; no wormhole locking.
// PARAMETERS
//  NUM_INPUTS   5   number of requesting input modules (index 0..NUM_INPUTS-1)
//  DATA_WIDTH   32  packet width
//  OUT_DEPTH    4   output FIFO entries; power of 2, >=2
//  CNT_WIDTH    16  width of the packet-sent statistics counter
// PORTS
//  clk        in   1                     clock, all state on rising edge
//  rst_n      in   1                     asynchronous active-low reset
//  req_data   in   NUM_INPUTS*DATA_WIDTH packet from input i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_valid  in   NUM_INPUTS            input i holds a packet for this direction
//  req_ready  out  NUM_INPUTS            one-hot grant; packet i is consumed this cycle when high
//  out_packet out  DATA_WIDTH            head-of-FIFO packet to link
//  out_valid  out  1                     FIFO not empty
//  out_ready  in   1                     link accepts out_packet this cycle
//  pkt_count  out  CNT_WIDTH             packets delivered on link since reset, wraps
//  full       out  1                     FIFO full (no grants issued)
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, rd/wr pointers=0, rr_ptr=0, pkt_count=0;
//   out_valid=0, full=0, req_ready=0. A reset mid-transfer discards buffered packets.
//  Arbitration (combinational):
//   - if full=1, req_ready=0.
//   - Otherwise, search i = rr_ptr, rr_ptr+1, ... mod NUM_INPUTS; the first with req_valid=1 is granted.
//   - req_ready has at most one bit set; req_ready[i] never asserts without req_valid[i].
//  Grant = transfer: requester i sees req_ready[i]=1 and must treat the packet as consumed that cycle.
//   rr_ptr <= (i+1) mod NUM_INPUTS on the edge; rr_ptr unchanged when no grant.
//  Push: on a grant, the FIFO writes req_data[i] at wr_ptr; wr_ptr increments mod OUT_DEPTH.
//  Pop: when out_valid && out_ready, rd_ptr increments and pkt_count increments (wraps 2^CNT_WIDTH-1 -> 0).
//  Occupancy rules:
//   - Push and pop in the same cycle leave occupancy unchanged.
//   - While full, no push occurs even if a pop happens that cycle; grants are gated on the registered full.
//   - With the FIFO empty, out_valid=0 and out_packet is don't-care.
//  Latency:
//   - Packet granted in cycle N appears on out_packet with out_valid=1 in cycle N+1 when the FIFO was empty.
//   - No combinational path from req_* to out_*, and none from out_ready to req_ready.
//  Throughput: 1 packet/cycle sustained when out_ready stays high (occupancy <= 1).
//  full = (count == OUT_DEPTH); count width = clog2(OUT_DEPTH)+1.
//  Ordering: packets leave in grant order; no reordering or duplication.
//  Changing req_valid without a grant is permitted; no state changes.
// TESTING
//  1. Reset, only req_valid[2]=1, data 0xA5A5_0002, out_ready=1:
//     req_ready=5'b00100 in cycle 0; out_valid=1 and out_packet=0xA5A5_0002 in cycle 1; pkt_count=1.
//  2. All 5 req_valid held, out_ready=1, rr_ptr=0:
//     grants 0,1,2,3,4,0 in successive cycles; packets appear on the link in the same order.
//  3. out_ready=0, input 1 streams 0x100..0x105:
//     after 4 grants full=1 and req_ready=0; out_ready=1 pops 0x100..0x103 in order,
//     then 0x104 and 0x105 are granted.
//  4. FIFO holds 2 entries, out_ready=1, new grant same cycle: occupancy stays 2 and
//     pkt_count increments by 1.
//  5. Assert rst_n=0 mid-stream with 3 entries buffered:
//     out_valid=0, pkt_count=0, full=0 immediately; the next grant after release goes to the lowest valid index.
//  6. With CNT_WIDTH=4, send 17 packets: pkt_count reads 15 and then 0 (wrap); the 17th delivered packet reads 1.

Source files
------------

// File: rtl/output_port.sv
// Per-direction output stage of a NoC router: round-robin arbitration over the
// input modules' VC read ports, a small output FIFO, and a valid/ready outbound link.
module output_port #(
   parameter int NUM_INPUTS = 5,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_DEPTH  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_INPUTS-1:0]            req_valid,
   output logic [NUM_INPUTS-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]            out_packet,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [CNT_WIDTH-1:0]             pkt_count,
   output logic                             full
);

   // Handshakes: a transfer happens on a cycle where valid and ready are both high.
   // On the request side req_ready is the grant itself, so the requester must
   // drop or advance its packet after any cycle where its req_ready was high.

   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [IDX_W-1:0]      rr_ptr;

   logic                  grant;
   logic [IDX_W-1:0]      grant_idx;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop;

   assign full       = (count == CNT_W'(OUT_DEPTH));
   assign out_valid  = (count != '0);
   assign out_packet = mem[rd_ptr];
   assign pop        = out_valid && out_ready;

   // Grants depend only on registered full, never on out_ready, so a pop in the
   // same cycle cannot open a slot for a push.
   always_comb begin
      int j;
      j         = 0;
      grant     = 1'b0;
      grant_idx = '0;
      push_data = '0;
      req_ready = '0;
      if (!full) begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
            if (!grant && req_valid[j]) begin
               grant     = 1'b1;
               grant_idx = IDX_W'(j);
               push_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      if (grant) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rr_ptr    <= '0;
         pkt_count <= '0;
      end else begin
         if (grant) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            pkt_count <= pkt_count + 1'b1;
         end
         case ({grant, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (grant) mem[wr_ptr] <= push_data;
   end

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: arbitration order, FIFO fill/drain, reset
// mid-stream and statistics counter wrap (counter built 4 bits wide).
module tb_output_port;
   localparam int NI = 5;
   localparam int DW = 32;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NI*DW-1:0]  req_data = '0;
   logic [NI-1:0]     req_valid = '0;
   logic [NI-1:0]     req_ready;
   logic [DW-1:0]     out_packet;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CW-1:0]     pkt_count;
   logic              full;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   output_port #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .OUT_DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
      .req_ready(req_ready), .out_packet(out_packet), .out_valid(out_valid),
      .out_ready(out_ready), .pkt_count(pkt_count), .full(full)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = '0;
      req_data = '0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++;
      if (req_ready !== 5'b00000) begin errors++; $display("FAIL reset_req_ready got %b exp 00000", req_ready); end
      checks++;
      if (pkt_count !== 4'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      @(posedge clk); #1;
      req_valid = 5'b00100;
      req_data[2*DW +: DW] = 32'hA5A5_0002;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 5'b00100) begin errors++; $display("FAIL single_grant got %b exp 00100", req_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_c0_valid got %b exp 0", out_valid); end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_packet !== 32'hA5A5_0002) begin
         errors++; $display("FAIL single_out got v=%b %h exp v=1 a5a50002", out_valid, out_packet);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (pkt_count !== 4'd1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL single_count got cnt=%0d v=%b exp cnt=1 v=0", pkt_count, out_valid);
      end
   endtask

   task automatic test_round_robin();
      int exp_grant[6] = '{0, 1, 2, 3, 4, 0};
      logic [DW-1:0] e;
      apply_reset();
      exp_q.delete();
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (c < 6) begin
            req_valid = '1;
            for (int i = 0; i < NI; i++) req_data[i*DW +: DW] = 32'h200 + i;
         end else begin
            req_valid = '0;
         end
         @(negedge clk);
         if (c < 6) begin
            checks++;
            if (req_ready !== (5'b1 << exp_grant[c])) begin
               errors++; $display("FAIL rr_grant c%0d got %b exp idx %0d", c, req_ready, exp_grant[c]);
            end
            exp_q.push_back(32'h200 + exp_grant[c]);
         end
         if (c >= 1 && c <= 6) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_packet !== e) begin
               errors++; $display("FAIL rr_order c%0d got v=%b %h exp %h", c, out_valid, out_packet, e);
            end
         end
         if (c == 7) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid); end
         end
      end
   endtask

   task automatic test_full();
      // columns: grant to input 1, full, out_valid, out_packet
      logic       t_gnt[12] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
      logic       t_ful[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      logic       t_ov [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [DW-1:0] t_pk[12] = '{0, 'h100, 'h100, 'h100, 'h100, 'h100, 'h101, 'h102,
                                  'h103, 'h104, 'h105, 0};
      int granted = 0;
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         req_valid = (c <= 7) ? 5'b00010 : 5'b00000;
         req_data[1*DW +: DW] = 32'h100 + granted;
         out_ready = (c >= 5);
         @(negedge clk);
         checks++;
         if (req_ready !== {3'b000, t_gnt[c], 1'b0} || full !== t_ful[c] || out_valid !== t_ov[c]) begin
            errors++;
            $display("FAIL full_c%0d got rdy=%b full=%b v=%b exp g=%b f=%b v=%b",
                     c, req_ready, full, out_valid, t_gnt[c], t_ful[c], t_ov[c]);
         end
         if (t_ov[c]) begin
            checks++;
            if (out_packet !== t_pk[c]) begin
               errors++; $display("FAIL full_data_c%0d got %h exp %h", c, out_packet, t_pk[c]);
            end
         end
         if (t_gnt[c]) granted++;
      end
      checks++;
      if (pkt_count !== 4'd6) begin errors++; $display("FAIL full_count got %0d exp 6", pkt_count); end
   endtask

   task automatic test_push_pop();
      apply_reset();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         req_valid = 5'b01000;
         req_data[3*DW +: DW] = 32'h400 + c;
      end
      @(posedge clk); #1;
      req_data[3*DW +: DW] = 32'h402;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 5'b01000 || out_packet !== 32'h400) begin
         errors++; $display("FAIL pp_same_cycle got rdy=%b %h exp 01000 400", req_ready, out_packet);
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (pkt_count !== 4'd1 || out_packet !== 32'h401 || full !== 1'b0) begin
         errors++; $display("FAIL pp_after got cnt=%0d %h full=%b exp 1 401 0", pkt_count, out_packet, full);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_packet !== 32'h402) begin
         errors++; $display("FAIL pp_second got v=%b %h exp 1 402", out_valid, out_packet);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || pkt_count !== 4'd3) begin
         errors++; $display("FAIL pp_empty got v=%b cnt=%0d exp 0 3", out_valid, pkt_count);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         req_valid = 5'b01000;
         req_data[3*DW +: DW] = 32'h500 + c;
         out_ready = (c == 1);
      end
      @(posedge clk); #1;
      req_valid = '0;
      out_ready = 1'b0;
      checks++;
      if (pkt_count !== 4'd1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL mr_before got cnt=%0d v=%b exp 1 1", pkt_count, out_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || pkt_count !== 4'd0 || full !== 1'b0) begin
         errors++; $display("FAIL mr_async got v=%b cnt=%0d full=%b exp 0 0 0", out_valid, pkt_count, full);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      req_valid = 5'b11010;
      req_data[1*DW +: DW] = 32'h511;
      req_data[3*DW +: DW] = 32'h533;
      req_data[4*DW +: DW] = 32'h544;
      @(negedge clk);
      checks++;
      if (req_ready !== 5'b00010) begin errors++; $display("FAIL mr_grant got %b exp 00010", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_packet !== 32'h511) begin
         errors++; $display("FAIL mr_data got v=%b %h exp 1 511", out_valid, out_packet);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         req_valid = (c < 17) ? 5'b10000 : 5'b00000;
         req_data[4*DW +: DW] = 32'h600 + c;
         @(negedge clk);
         if (c >= 1) begin
            checks++;
            if (pkt_count !== 4'((c - 1) % 16)) begin
               errors++; $display("FAIL wrap_count c%0d got %0d exp %0d", c, pkt_count, (c - 1) % 16);
            end
         end
         if (c >= 1 && c <= 17) begin
            checks++;
            if (out_valid !== 1'b1 || out_packet !== 32'h600 + c - 1) begin
               errors++; $display("FAIL wrap_data c%0d got v=%b %h exp %h", c, out_valid, out_packet, 32'h600 + c - 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_push_pop();
      test_mid_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
